// File: rtl/cnt_cmd_gen_if.sv
// cnt_cmd_gen_if: valid/ready command channel carrying direction and step count
interface cnt_cmd_gen_if #(
    parameter int LEN_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_up;
    logic [LEN_WIDTH-1:0] cmd_len;

    modport master (
        output cmd_valid,
        output cmd_up,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_up,
        input  cmd_len,
        output cmd_ready
    );
endinterface

// File: rtl/cnt_cmd_gen.sv
// cnt_cmd_gen: issues counted up/down steps to a counter, halting before any wrap or on overflow
module cnt_cmd_gen #(
    parameter int COUNTER_WIDTH = 4,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cnt_cmd_gen_if.slave             cmd,
    input  logic                     ovflw_i,
    output logic                     act_o,
    output logic                     up_dwn_n_o,
    output logic [COUNTER_WIDTH-1:0] shadow_count_o,
    output logic [LEN_WIDTH-1:0]     steps_left_o,
    output logic                     done_o,
    output logic                     halted_o
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t                   state_q, state_d;
    logic                     dir_q, dir_d;
    logic                     done_q, done_d;
    logic [COUNTER_WIDTH-1:0] shadow_q, shadow_d;
    logic [LEN_WIDTH-1:0]     steps_q, steps_d;
    logic                     hs, boundary, last, zero_len;

    assign hs       = cmd.cmd_valid && cmd.cmd_ready;
    assign zero_len = cmd.cmd_len == '0;
    assign boundary = dir_q ? (&shadow_q) : ~(|shadow_q);
    assign last     = steps_q == LEN_WIDTH'(1);

    assign cmd.cmd_ready  = state_q == IDLE;
    assign halted_o       = state_q == HALT;
    assign up_dwn_n_o     = dir_q;
    assign act_o          = (state_q == RUN) && !boundary;
    assign shadow_count_o = shadow_q;
    assign steps_left_o   = steps_q;
    assign done_o         = done_q;

    // overflow wins over every transition, but the step already issued this cycle still counts
    always_comb begin
        state_d  = (state_q == HALT || ovflw_i) ? HALT :
                   (state_q == IDLE) ? ((hs && !zero_len) ? RUN : IDLE) :
                   boundary ? HALT : last ? IDLE : RUN;
        done_d   = !ovflw_i && ((hs && zero_len) || (act_o && last));
        dir_d    = hs ? cmd.cmd_up : dir_q;
        steps_d  = hs ? cmd.cmd_len : act_o ? steps_q - LEN_WIDTH'(1) : steps_q;
        shadow_d = act_o ? (dir_q ? shadow_q + COUNTER_WIDTH'(1) : shadow_q - COUNTER_WIDTH'(1)) : shadow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b1;
            done_q   <= 1'b0;
            shadow_q <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            shadow_q <= shadow_d;
            steps_q  <= steps_d;
        end
    end
endmodule

// File: doc/cnt_cmd_gen.md
# cnt_cmd_gen

Command sequencer that drives the `act` and `up_dwn_n` inputs of the up/down counter state machine. It accepts (direction, length) commands over a valid/ready handshake and issues exactly `length` counting cycles. It keeps a shadow copy of the expected counter value and refuses any step that would wrap the counter. It halts permanently when a step would wrap or when the counter reports overflow.

## Interface
- `COUNTER_WIDTH`, default 4: width of the controlled counter and of `shadow_count`.
- `LEN_WIDTH`, default 8: width of the command length field and of `steps_left`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  generator can accept a command.
- `cmd_up`  in  1  direction: 1 = count up, 0 = count down.
- `cmd_len`  in  LEN_WIDTH  number of count steps; 0 is a legal no-op.
- `act`  out  1  to counter: count enable.
- `up_dwn_n`  out  1  to counter: direction.
- `ovflw`  in  1  overflow flag from the counter.
- `shadow_count`  out  COUNTER_WIDTH  predicted counter value.
- `steps_left`  out  LEN_WIDTH  steps remaining in the current command.
- `done`  out  1  one-cycle pulse when a command completes.
- `halted`  out  1  sticky halt indicator.

## Operation
- States: IDLE, RUN, HALT.
- Reset values (rst_n low at a clock edge):
  - State: IDLE.
  - Outputs: `shadow_count`=0, `steps_left`=0, `done`=0, `halted`=0, `act`=0, `up_dwn_n`=1 (registered direction `dir_q` resets to 1).
- Reset asserted in any state, including mid-RUN or HALT, restores all reset values at that edge.
- Combinational outputs:
  - `cmd_ready` = (state==IDLE).
  - `halted` = (state==HALT).
  - `up_dwn_n` = `dir_q`.
  - `act` = (state==RUN) && !boundary.
  - boundary = (`dir_q`=1 && `shadow_count`==2^COUNTER_WIDTH-1) || (`dir_q`=0 && `shadow_count`==0).
- IDLE:
  - A handshake (`cmd_valid` && `cmd_ready`) latches `dir_q`←`cmd_up` and `steps_left`←`cmd_len`.
  - If `cmd_len`==0: stay in IDLE and pulse `done` in the next cycle.
  - Otherwise go to RUN.
- RUN, each cycle:
  - If boundary: go to HALT. `act` is 0 this cycle, `shadow_count` and `steps_left` are held, and no `done` is issued.
  - Otherwise (`act`=1): `shadow_count` ±1 per `dir_q`, modulo 2^COUNTER_WIDTH (never wraps in practice because of the boundary check); `steps_left`−1.
  - If `steps_left`==1: go to IDLE and pulse `done`.
- `ovflw` sampled high in IDLE or RUN: next state is HALT, and it takes priority over every other transition.
  - The RUN step in that same cycle still executes: `act` stays high and the counters update.
  - No `done` is issued, even if it was the last step.
- HALT: absorbing. `act`=0, `cmd_ready`=0, `done`=0. `shadow_count` and `steps_left` are frozen. Only reset exits.
- `cmd_*` inputs are ignored whenever `cmd_ready`=0.

## Timing
- For a handshake at cycle N with L>0:
  - `act`=1 in cycles N+1 … N+L.
  - `done`=1 and `cmd_ready`=1 at cycle N+L+1.
- For L=0: `done`=1 at N+1, and `cmd_ready` stays 1 throughout.
- Back-to-back commands:
  - A new command can be accepted in the same cycle `done` is high.
  - Its first `act` cycle follows one cycle later, so there is always at least one `act`=0 cycle between commands.
- `shadow_count` and `steps_left` reflect all steps issued up to the previous edge.
- Boundary-triggered HALT is visible (`halted`=1) in the cycle after the boundary was detected.
- Simultaneous last step and `ovflw`: HALT, no `done`, `steps_left`=0.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `cmd_valid`=1 → `act`=0, `cmd_ready`=1, `shadow_count`=0, `halted`=0, `done`=0, and no command accepted.
- Up 5: handshake at cycle 0 with `cmd_up`=1, `cmd_len`=5 → `act`=1 and `up_dwn_n`=1 in cycles 1–5; `shadow_count`=5 and `done`=1 at cycle 6.
- Back-to-back: `cmd_valid` held with up 3 then down 2 → `act` up in cycles 1–3, `done` and second handshake at cycle 4, `act` down in cycles 5–6, `done` at 7, `shadow_count`=1.
- Up boundary (COUNTER_WIDTH=4): from 0, up with `cmd_len`=20 → 15 `act` cycles (1–15); boundary at cycle 16 with `act`=0; `halted`=1 from cycle 17; `shadow_count`=15, `steps_left`=5, no `done`; later commands ignored.
- Down at zero and zero length:
  - From reset, down with `cmd_len`=1 → `act` never high, `halted`=1 two cycles after the handshake, `steps_left`=1.
  - `cmd_len`=0 → `done` pulse only, `act` stays 0.
- `ovflw` and reset mid-run:
  - Up 10, `ovflw`=1 in cycle 4 → `act` high in cycles 1–4, `halted` from cycle 5, `shadow_count`=4.
  - Then `rst_n`=0 for one cycle → all reset values, and a new command is accepted normally.
